// File: rtl/video_timing_decoder_if.sv
// -----------------------------------------------------------------------------
// video_timing_decoder_if
// Groups the timing-source inputs and the recovered-timing outputs of
// video_timing_decoder into one bundle.
//   hsync_in, vsync_in : active-high sync pulses from the timing source
//   hbl_in, vbl_in     : active-high horizontal / vertical blanking
//   hc, vc             : recovered pixel / line position (0 = first active)
//   htotal, vtotal     : measured line length (ticks) / frame length (lines)
//   hactive, vactive   : measured active pixels per line / lines per frame
//   locked             : timing has been stable for at least two frames
// Modports: master = timing source side, slave = decoder side.
// -----------------------------------------------------------------------------
interface video_timing_decoder_if;
    logic       hsync_in;
    logic       vsync_in;
    logic       hbl_in;
    logic       vbl_in;
    logic [8:0] hc;
    logic [8:0] vc;
    logic [8:0] htotal;
    logic [8:0] vtotal;
    logic [8:0] hactive;
    logic [8:0] vactive;
    logic       locked;

    modport master (
        output hsync_in, vsync_in, hbl_in, vbl_in,
        input  hc, vc, htotal, vtotal, hactive, vactive, locked
    );

    modport slave (
        input  hsync_in, vsync_in, hbl_in, vbl_in,
        output hc, vc, htotal, vtotal, hactive, vactive, locked
    );
endinterface

// File: rtl/video_timing_decoder.sv
// -----------------------------------------------------------------------------
// video_timing_decoder
// Recovers pixel/line position and measures the raster geometry of an incoming
// sync/blank timing stream, and reports lock once two consecutive frames agree.
// Ports:
//   clk     : system clock, all state on its rising edge
//   reset   : asynchronous active-low reset, clears all state immediately
//   clk_pix : pixel clock enable; state advances only on clk edges with
//             clk_pix=1 (a "tick")
//   bus     : video_timing_decoder_if.slave (sync/blank in, measurements out)
// All counters are 9-bit unsigned and saturate at 511 instead of wrapping.
// -----------------------------------------------------------------------------
module video_timing_decoder (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_pix,
    video_timing_decoder_if.slave        bus
);

    localparam logic [8:0] CNT_MAX = 9'd511;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_t;

    // Saturating +1 used by every counter and measurement.
    function automatic logic [8:0] sat_inc(input logic [8:0] val);
        return (val == CNT_MAX) ? val : (val + 9'd1);
    endfunction

    // Previous-tick input samples and the "first tick seen" flag.
    logic        hs_smp_r, vs_smp_r, hb_smp_r, vb_smp_r;
    logic        primed_r;

    // Internal line/frame counters and pending vsync marker.
    logic [8:0]  h_r, v_r;
    logic        vs_pend_r;
    logic        vb_line_r;
    logic [8:0]  ha_cnt_r, va_cnt_r;

    // Output registers.
    logic [8:0]  hc_r, vc_r, htotal_r, vtotal_r, hactive_r, vactive_r;
    logic        locked_r;

    // Lock FSM.
    lock_state_t state_r, state_nxt_s;
    logic [8:0]  ref_h_r, ref_v_r;
    logic        ref_load_s;

    // Edge detection and derived events.
    logic        edge_en_s;
    logic        hs_rise_s, vs_rise_s, hb_rise_s, hb_fall_s, vb_rise_s;
    logic        frame_evt_s, timeout_s, line_mismatch_s, pair_match_s;
    logic [8:0]  htotal_nxt_s, vtotal_nxt_s;

    // The very first tick after reset only loads the samples, so an input
    // that is already high at release is never reported as an edge.
    assign edge_en_s       = clk_pix & primed_r;
    assign hs_rise_s       = edge_en_s &  bus.hsync_in & ~hs_smp_r;
    assign vs_rise_s       = edge_en_s &  bus.vsync_in & ~vs_smp_r;
    assign hb_rise_s       = edge_en_s &  bus.hbl_in   & ~hb_smp_r;
    assign hb_fall_s       = edge_en_s & ~bus.hbl_in   &  hb_smp_r;
    assign vb_rise_s       = edge_en_s &  bus.vbl_in   & ~vb_smp_r;

    assign htotal_nxt_s    = sat_inc(h_r);
    assign vtotal_nxt_s    = sat_inc(v_r);
    // A frame closes at the first hsync rise after a vsync rise.
    assign frame_evt_s     = hs_rise_s & vs_pend_r;
    assign timeout_s       = clk_pix & (h_r == CNT_MAX);
    assign line_mismatch_s = hs_rise_s & (htotal_nxt_s != ref_h_r);
    assign pair_match_s    = (htotal_nxt_s == ref_h_r) && (vtotal_nxt_s == ref_v_r);

    // Input sample registers and priming flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_smp_r <= 1'b0;
            vs_smp_r <= 1'b0;
            hb_smp_r <= 1'b0;
            vb_smp_r <= 1'b0;
            primed_r <= 1'b0;
        end else if (clk_pix) begin
            hs_smp_r <= bus.hsync_in;
            vs_smp_r <= bus.vsync_in;
            hb_smp_r <= bus.hbl_in;
            vb_smp_r <= bus.vbl_in;
            primed_r <= 1'b1;
        end
    end

    // Line counter h and line-length measurement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_r      <= 9'd0;
            htotal_r <= 9'd0;
        end else if (clk_pix) begin
            if (hs_rise_s) begin
                h_r      <= 9'd0;
                htotal_r <= htotal_nxt_s;
            end else begin
                h_r      <= htotal_nxt_s;
            end
        end
    end

    // Frame counter v, vsync pending marker and frame-length measurement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_r       <= 9'd0;
            vtotal_r  <= 9'd0;
            vs_pend_r <= 1'b0;
        end else if (clk_pix) begin
            if (frame_evt_s) begin
                v_r       <= 9'd0;
                vtotal_r  <= vtotal_nxt_s;
                // A vsync rise on the closing tick belongs to the next frame.
                vs_pend_r <= vs_rise_s;
            end else if (hs_rise_s) begin
                v_r       <= vtotal_nxt_s;
                vs_pend_r <= vs_pend_r | vs_rise_s;
            end else begin
                vs_pend_r <= vs_pend_r | vs_rise_s;
            end
        end
    end

    // Recovered pixel position: restarts at the end of horizontal blanking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hc_r <= 9'd0;
        end else if (clk_pix) begin
            if (hb_fall_s) begin
                hc_r <= 9'd0;
            end else begin
                hc_r <= sat_inc(hc_r);
            end
        end
    end

    // Recovered line position: restarts on the first line after vertical
    // blanking, judged by the vbl level seen at each line start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vc_r      <= 9'd0;
            vb_line_r <= 1'b0;
        end else if (clk_pix && hs_rise_s) begin
            vb_line_r <= bus.vbl_in;
            if (!bus.vbl_in && vb_line_r) begin
                vc_r <= 9'd0;
            end else begin
                vc_r <= sat_inc(vc_r);
            end
        end
    end

    // Active pixels per line: ticks with hbl low, latched at hbl rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ha_cnt_r  <= 9'd0;
            hactive_r <= 9'd0;
        end else if (clk_pix) begin
            if (hb_rise_s) begin
                hactive_r <= ha_cnt_r;
                ha_cnt_r  <= 9'd0;
            end else if (!bus.hbl_in) begin
                ha_cnt_r  <= sat_inc(ha_cnt_r);
            end
        end
    end

    // Active lines per frame: lines starting with vbl low, latched at vbl rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            va_cnt_r  <= 9'd0;
            vactive_r <= 9'd0;
        end else if (clk_pix) begin
            if (vb_rise_s) begin
                vactive_r <= va_cnt_r;
                va_cnt_r  <= 9'd0;
            end else if (hs_rise_s && !bus.vbl_in) begin
                va_cnt_r  <= sat_inc(va_cnt_r);
            end
        end
    end

    // Lock FSM next state; timeout outranks a line mismatch, which outranks
    // the frame-event comparison.
    always_comb begin
        state_nxt_s = state_r;
        ref_load_s  = 1'b0;
        if (timeout_s) begin
            state_nxt_s = ST_SEARCH;
        end else if ((state_r == ST_LOCKED) && line_mismatch_s) begin
            state_nxt_s = ST_SEARCH;
        end else if (frame_evt_s) begin
            case (state_r)
                ST_SEARCH: begin
                    state_nxt_s = ST_VERIFY;
                    ref_load_s  = 1'b1;
                end
                ST_VERIFY: begin
                    if (pair_match_s) begin
                        state_nxt_s = ST_LOCKED;
                    end else begin
                        state_nxt_s = ST_VERIFY;
                        ref_load_s  = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (vtotal_nxt_s != ref_v_r) begin
                        state_nxt_s = ST_SEARCH;
                    end else begin
                        state_nxt_s = ST_LOCKED;
                    end
                end
                default: begin
                    state_nxt_s = ST_SEARCH;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Lock FSM state register with registered locked flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_SEARCH;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            locked_r <= (state_nxt_s == ST_LOCKED);
        end
    end

    // Reference geometry captured when entering or retrying verification.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_h_r <= 9'd0;
            ref_v_r <= 9'd0;
        end else if (ref_load_s) begin
            ref_h_r <= htotal_nxt_s;
            ref_v_r <= vtotal_nxt_s;
        end
    end

    assign bus.hc      = hc_r;
    assign bus.vc      = vc_r;
    assign bus.htotal  = htotal_r;
    assign bus.vtotal  = vtotal_r;
    assign bus.hactive = hactive_r;
    assign bus.vactive = vactive_r;
    assign bus.locked  = locked_r;

endmodule

// File: tb/tb_video_timing_decoder.sv
// -----------------------------------------------------------------------------
// tb_video_timing_decoder
// Drives a synthetic 387-tick x 262-line raster into video_timing_decoder and
// compares the recovered geometry and lock state with hand-computed values.
// -----------------------------------------------------------------------------
module tb_video_timing_decoder;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic clk_pix = 1'b0;

    video_timing_decoder_if bus_if ();

    video_timing_decoder dut (
        .clk     (clk),
        .reset   (reset),
        .clk_pix (clk_pix),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int div;
        int hb_s;
        int hb_e;
        int vb_s;
        int vb_e;
        int exp_htotal;
        int exp_vtotal;
        int exp_hactive;
        int exp_vactive;
    } scen_t;

    scen_t tbl [3];

    int n_checks = 0;
    int n_fail   = 0;
    int div      = 1;
    int hb_s     = 352;
    int hb_e     = 31;
    int vb_s     = 248;
    int vb_e     = 7;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic hs, input logic vs, input logic hb, input logic vb);
        bus_if.hsync_in = hs;
        bus_if.vsync_in = vs;
        bus_if.hbl_in   = hb;
        bus_if.vbl_in   = vb;
    endtask

    // One pixel tick: clk_pix high for one clk, then low for div-1 clks.
    task automatic tick(input logic hs, input logic vs, input logic hb, input logic vb);
        set_inputs(hs, vs, hb, vb);
        clk_pix = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k < div; k++) begin
            clk_pix = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Ticks t0..t1 of source line l (hsync 364-379, vsync lines 252-255).
    task automatic drive_range(input int l, input int t0, input int t1);
        for (int t = t0; t <= t1; t++) begin
            tick((t >= 364) && (t <= 379), (l >= 252) && (l <= 255),
                 (t >= hb_s) || (t <= hb_e), (l >= vb_s) || (l <= vb_e));
        end
    endtask

    task automatic drive_lines(input int l0, input int l1);
        for (int l = l0; l <= l1; l++) begin
            drive_range(l, 0, 386);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hc"},      int'(bus_if.hc),      0);
        check({tag, "_vc"},      int'(bus_if.vc),      0);
        check({tag, "_htotal"},  int'(bus_if.htotal),  0);
        check({tag, "_vtotal"},  int'(bus_if.vtotal),  0);
        check({tag, "_hactive"}, int'(bus_if.hactive), 0);
        check({tag, "_vactive"}, int'(bus_if.vactive), 0);
        check({tag, "_locked"},  int'(bus_if.locked),  0);
    endtask

    // Reset asserted between clock edges with clk_pix low; outputs must clear
    // before any further clk edge. Inputs are set to rel_lvl for the release.
    task automatic do_reset(input string tag, input logic rel_lvl);
        clk_pix = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero(tag);
        repeat (3) @(posedge clk);
        set_inputs(rel_lvl, rel_lvl, rel_lvl, rel_lvl);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{div: 4, hb_s: 352, hb_e: 31, vb_s: 248, vb_e: 7,
                   exp_htotal: 387, exp_vtotal: 262, exp_hactive: 320, exp_vactive: 240};
        tbl[1] = '{div: 1, hb_s: 336, hb_e: 47, vb_s: 240, vb_e: 15,
                   exp_htotal: 387, exp_vtotal: 262, exp_hactive: 288, exp_vactive: 224};
        tbl[2] = '{div: 1, hb_s: 352, hb_e: 31, vb_s: 248, vb_e: 7,
                   exp_htotal: 387, exp_vtotal: 262, exp_hactive: 320, exp_vactive: 240};

        set_inputs(1'b0, 1'b0, 1'b0, 1'b0);

        // Table of full-raster scenarios; each starts with a reset, and every
        // reset after the first lands mid-line while the decoder is locked.
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                check("pre_rst_locked", int'(bus_if.locked), 1);
            end
            do_reset("rst", 1'b0);
            div  = tbl[i].div;
            hb_s = tbl[i].hb_s;
            hb_e = tbl[i].hb_e;
            vb_s = tbl[i].vb_s;
            vb_e = tbl[i].vb_e;
            drive_lines(0, 261);
            drive_lines(0, 261);
            check("locked_before_3rd_frame", int'(bus_if.locked), 0);
            drive_lines(0, 261);
            check("htotal",  int'(bus_if.htotal),  tbl[i].exp_htotal);
            check("vtotal",  int'(bus_if.vtotal),  tbl[i].exp_vtotal);
            check("hactive", int'(bus_if.hactive), tbl[i].exp_hactive);
            check("vactive", int'(bus_if.vactive), tbl[i].exp_vactive);
            check("locked",  int'(bus_if.locked),  1);
            drive_range(0, 0, 99);
        end

        // Position recovery mid-frame on the locked standard raster.
        drive_range(0, 100, 386);
        drive_lines(1, 19);
        drive_range(20, 0, 99);
        check("hc_mid", int'(bus_if.hc), 67);
        check("vc_mid", int'(bus_if.vc), 11);
        drive_range(20, 100, 351);
        check("hc_last_active", int'(bus_if.hc), 319);
        drive_range(20, 352, 386);
        drive_lines(21, 99);

        // One 388-tick line drops lock at the following hsync rise.
        drive_range(100, 0, 387);
        drive_range(101, 0, 363);
        check("long_line_pre_locked", int'(bus_if.locked), 1);
        drive_range(101, 364, 364);
        check("long_line_locked", int'(bus_if.locked), 0);
        check("long_line_htotal", int'(bus_if.htotal), 388);
        drive_range(101, 365, 386);
        drive_lines(102, 261);
        check("relock_after_1_frame", int'(bus_if.locked), 0);
        drive_lines(0, 261);
        check("relock_after_2_frames", int'(bus_if.locked), 1);
        check("relock_htotal", int'(bus_if.htotal), 387);
        check("relock_vtotal", int'(bus_if.vtotal), 262);

        // hsync held low: h saturates at 511 and the timeout drops lock.
        for (int k = 0; k < 400; k++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1);
        end
        check("timeout_pre_locked", int'(bus_if.locked), 1);
        for (int k = 0; k < 200; k++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1);
        end
        check("timeout_locked", int'(bus_if.locked), 0);
        check("timeout_htotal", int'(bus_if.htotal), 387);
        check("timeout_hc_sat", int'(bus_if.hc), 511);

        // Release with every input already high: no edge on the first tick.
        div = 1;
        do_reset("rst_hi", 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1, 1'b1, 1'b1);
        end
        check("no_edge_htotal", int'(bus_if.htotal), 0);
        check("no_edge_vc",     int'(bus_if.vc),     0);
        check("no_edge_hc",     int'(bus_if.hc),     3);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        check("first_real_edge_htotal", int'(bus_if.htotal), 5);
        check("first_real_edge_vc",     int'(bus_if.vc),     1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_decoder.md
VIDEO_TIMING_DECODER -- requirements
Module: video_timing_decoder

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state is clocked on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset that clears all state immediately, independent of clk.
REQ-003 SHALL have port clk_pix, input, 1, pixel clock enable; state advances only on clk edges where clk_pix=1 (a "tick").
REQ-004 SHALL have ports hsync_in, vsync_in, hbl_in, vbl_in, input, 1 each, active-high sync and blank signals from a timing source.
REQ-005 SHALL have ports hc and vc, output, 9 each, recovered pixel and line position, where 0 is the first active pixel and the first active line.
REQ-006 SHALL have ports htotal and vtotal, output, 9 each, measured line length in ticks and frame length in lines.
REQ-007 SHALL have ports hactive and vactive, output, 9 each, measured active pixels per line and active lines per frame.
REQ-008 SHALL have port locked, output, 1, high while the timing has been stable for at least 2 consecutive frames.

Function
REQ-009 SHALL register all four inputs on each tick and detect an edge by comparing the current sample with the previous sample.
REQ-010 SHALL keep the internal line counter h running from one hsync rising edge to the next; on an hsync rising edge it SHALL latch htotal=h+1, set h=0 and increment the line counter v.
REQ-011 SHALL detect vsync rising edges on every tick; at the next hsync rising edge after such an edge it SHALL latch vtotal=v+1, set v=0 and raise an internal frame event.
REQ-012 SHALL set hc=0 on the tick where a falling edge of hbl_in is detected, and otherwise SHALL increment hc, saturating at 511.
REQ-013 SHALL update vc only at hsync rising edges: set vc=0 if vbl_in is sampled low and vbl was high on the previous line, otherwise increment vc, saturating at 511.
REQ-014 SHALL count ticks with hbl_in low and latch that count into hactive at each hbl rising edge.
REQ-015 SHALL count lines that start with vbl_in low and latch that count into vactive at each vbl rising edge.
REQ-016 SHALL saturate h at 511; reaching 511 is a line timeout, which SHALL force state SEARCH.
REQ-017 SHALL implement a lock FSM with states SEARCH, VERIFY and LOCKED, and locked=1 only in LOCKED.
REQ-018 SEARCH SHALL go to VERIFY on a frame event, storing the reference pair ref_h=htotal and ref_v=vtotal.
REQ-019 VERIFY SHALL go to LOCKED on a frame event with an exact match to the reference pair, and SHALL otherwise store the new pair and stay in VERIFY.
REQ-020 LOCKED SHALL go to SEARCH on any line whose htotal differs from ref_h, on a frame event whose vtotal differs from ref_v, or on a line timeout.
REQ-021 Priority for simultaneous events SHALL be: timeout, then line mismatch, then frame event.
REQ-022 All arithmetic SHALL be unsigned 9-bit; the +1 SHALL saturate at 511 and never wrap.

Reset
REQ-023 While reset=0, all outputs and internal counters SHALL be 0, the FSM SHALL be in SEARCH and the input samples SHALL be 0.
REQ-024 On reset release, no edge SHALL be detected on the first tick, even if an input is already high.
REQ-025 Reset asserted mid-frame SHALL clear locked within the same clk cycle, with no wait for clk_pix.

Verification
REQ-026 Drive the 6 MHz timing (htotal 387, hsync ticks 364-379, hbl ticks 352-31, vtotal 262, vbl lines 248-7, vsync lines 252-255) for 3 frames -> htotal=387, vtotal=262, hactive=320, vactive=240, and locked=1 after the 3rd frame event.
REQ-027 Drive the alternate timing (hbl ticks 336-47, vbl lines 240-15) -> hactive=288, vactive=224, htotal=387 and locked=1.
REQ-028 With the design locked, lengthen one line to 388 ticks -> locked=0 at that hsync edge, then locked=1 again after 2 further clean frames.
REQ-029 Hold hsync_in low for 600 ticks -> h saturates at 511, locked=0, and htotal keeps its last value.
REQ-030 Assert reset=0 mid-line while locked, with clk_pix=0 -> all outputs are 0 immediately; after release, inputs already high produce no edge on the first tick.
REQ-031 Toggle clk_pix with a 1/4 duty cycle -> results match REQ-026 exactly, with measurements in ticks, not clk cycles.
